// File: rtl/i2c_write_master.sv
// i2c_write_master
// Emits one I2C write transaction per accepted request:
//   START, {DEV_ADDR,W}, reg_addr, tx_data, STOP
// on an open-drain SCL/SDA pair. Each protocol step lasts one quarter of an
// SCL period (CLK_DIV system clocks), so SCL high and low phases are each
// 2*CLK_DIV clocks. A NACK on any byte skips straight to STOP and raises
// ack_error until the next acceptance.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset (0 = reset)
//   reg_addr   second byte on the bus
//   tx_data    third byte on the bus
//   tx_en      request, level-sampled in IDLE while tx_done is low
//   tx_done    completion strobe, 2 clocks wide
//   busy       high from acceptance through the end of STOP
//   ack_error  slave NACKed a byte of the last transaction
//   scl_o      SCL drive, 1 = released, 0 = pull low
//   sda_oe     1 = pull SDA low, 0 = release
//   sda_i      SDA line as seen on the pin (asynchronous)
module i2c_write_master #(
    parameter int         CLK_DIV  = 4,
    parameter logic [6:0] DEV_ADDR = 7'h3F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] reg_addr,
    input  logic [7:0] tx_data,
    input  logic       tx_en,
    output logic       tx_done,
    output logic       busy,
    output logic       ack_error,
    output logic       scl_o,
    output logic       sda_oe,
    input  logic       sda_i
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        ACK,
        STOP,
        DONE
    } state_t;

    localparam logic [9:0] QMAX = 10'(CLK_DIV - 1);

    state_t      state;
    logic [9:0]  qcnt;
    logic        tick;
    logic [1:0]  qtr;        // quarter within the current step
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] shreg;      // bit 23 is always the next bit to send
    logic [1:0]  done_cnt;
    logic        sda_p0;
    logic        sda_p1;

    assign tick = (qcnt == QMAX);

    // Quarter-period timebase; parked at 0 whenever the bus is not active so
    // every transaction starts on a full quarter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qcnt <= '0;
        end else if (state == IDLE || state == DONE || tick) begin
            qcnt <= '0;
        end else begin
            qcnt <= qcnt + 10'd1;
        end
    end

    // Two-flop synchroniser for the SDA pin; idles released-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
        end else begin
            sda_p0 <= sda_i;
            sda_p1 <= sda_p0;
        end
    end

    // Protocol FSM. Bus outputs are registered and written on the tick that
    // ends a quarter, i.e. they carry the value for the quarter being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            scl_o     <= 1'b1;
            sda_oe    <= 1'b0;
            tx_done   <= 1'b0;
            busy      <= 1'b0;
            ack_error <= 1'b0;
            qtr       <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shreg     <= '0;
            done_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_en && !tx_done) begin
                        shreg     <= {DEV_ADDR, 1'b0, reg_addr, tx_data};
                        busy      <= 1'b1;
                        ack_error <= 1'b0;
                        qtr       <= '0;
                        bit_cnt   <= '0;
                        byte_cnt  <= '0;
                        state     <= START;
                    end
                end

                START: begin
                    if (tick) begin
                        if (qtr == 2'd0) begin
                            qtr    <= 2'd1;
                            sda_oe <= 1'b1;          // SDA falls with SCL high
                        end else begin
                            qtr    <= 2'd0;
                            scl_o  <= 1'b0;
                            sda_oe <= ~shreg[23];
                            state  <= BIT;
                        end
                    end
                end

                BIT: begin
                    if (tick) begin
                        qtr <= qtr + 2'd1;
                        case (qtr)
                            2'd0, 2'd1: scl_o <= 1'b1;
                            2'd2:       scl_o <= 1'b0;
                            default: begin
                                shreg <= {shreg[22:0], 1'b0};
                                if (bit_cnt == 3'd7) begin
                                    bit_cnt <= '0;
                                    sda_oe  <= 1'b0;  // release for slave ACK
                                    state   <= ACK;
                                end else begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                    sda_oe  <= ~shreg[22];
                                end
                            end
                        endcase
                    end
                end

                ACK: begin
                    if (tick) begin
                        qtr <= qtr + 2'd1;
                        case (qtr)
                            2'd0, 2'd1: scl_o <= 1'b1;
                            2'd2: begin
                                scl_o <= 1'b0;
                                if (sda_p1) begin
                                    ack_error <= 1'b1;
                                end
                            end
                            default: begin
                                // ack_error was registered one quarter ago.
                                if (ack_error || byte_cnt == 2'd2) begin
                                    sda_oe <= 1'b1;
                                    state  <= STOP;
                                end else begin
                                    byte_cnt <= byte_cnt + 2'd1;
                                    sda_oe   <= ~shreg[23];
                                    state    <= BIT;
                                end
                            end
                        endcase
                    end
                end

                STOP: begin
                    if (tick) begin
                        qtr <= qtr + 2'd1;
                        case (qtr)
                            2'd0:    scl_o  <= 1'b1;
                            2'd1:    sda_oe <= 1'b0;  // SDA rises with SCL high
                            2'd2:    ;
                            default: begin
                                busy     <= 1'b0;
                                done_cnt <= '0;
                                state    <= DONE;
                            end
                        endcase
                    end
                end

                DONE: begin
                    case (done_cnt)
                        2'd0: begin
                            tx_done  <= 1'b1;
                            done_cnt <= 2'd1;
                        end
                        2'd1: done_cnt <= 2'd2;
                        default: begin
                            tx_done  <= 1'b0;
                            done_cnt <= '0;
                            state    <= IDLE;
                        end
                    endcase
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: three instances (CLK_DIV 4, 2, 1023) each with
// a simple I2C slave; a cycle-level waveform model built from the bus rules
// is checked against the selected instance on every negedge.
module tb_i2c_write_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  reg_addr = 8'h00;
    logic [7:0]  tx_data = 8'h00;
    logic [2:0]  tx_en = 3'b000;
    wire  [2:0]  done;
    wire  [2:0]  busy;
    wire  [2:0]  aerr;
    wire  [2:0]  scl;
    wire  [2:0]  sda_oe;
    wire  [2:0]  pull;
    wire  [2:0]  sda_line = ~(sda_oe | pull);
    wire  [2:0]  ev_stb;
    wire  [8:0]  ev_code [3];
    logic [2:0]  nack_cfg [3] = '{3'b000, 3'b000, 3'b000};

    int vectors = 0;
    int miscompares = 0;
    int sel = 0;
    logic [4:0] exp_q [$];   // {scl, sda_oe, busy, tx_done, ack_error}
    int log_q [$];            // 256 = START, 257 = STOP, else byte
    int exp_log [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DIV = (g == 0) ? 4 : (g == 1) ? 2 : 1023;
        logic       ps = 1'b1;
        logic       pd = 1'b1;
        logic       pl = 1'b0;
        logic [3:0] bc = 4'd0;
        logic [1:0] nb = 2'd0;
        logic [7:0] sh = 8'd0;
        logic       stb = 1'b0;
        logic [8:0] code = 9'd0;

        i2c_write_master #(.CLK_DIV(DIV), .DEV_ADDR(7'h3F)) u_dut (
            .clk(clk), .rst(rst_n), .reg_addr(reg_addr), .tx_data(tx_data),
            .tx_en(tx_en[g]), .tx_done(done[g]), .busy(busy[g]),
            .ack_error(aerr[g]), .scl_o(scl[g]), .sda_oe(sda_oe[g]),
            .sda_i(sda_line[g])
        );

        // Slave: decodes START/STOP/bytes, ACKs unless nack_cfg marks the byte.
        always @(posedge clk) begin
            stb <= 1'b0;
            ps  <= scl[g];
            pd  <= sda_line[g];
            if (ps && scl[g] && pd && !sda_line[g]) begin
                bc <= 4'd0; nb <= 2'd0; stb <= 1'b1; code <= 9'd256;
            end else if (ps && scl[g] && !pd && sda_line[g]) begin
                stb <= 1'b1; code <= 9'd257;
            end else if (!ps && scl[g]) begin
                if (bc < 4'd8) begin
                    sh <= {sh[6:0], sda_line[g]};
                    bc <= bc + 4'd1;
                    if (bc == 4'd7) begin
                        stb <= 1'b1; code <= {1'b0, sh[6:0], sda_line[g]};
                    end
                end else begin
                    bc <= 4'd0; nb <= nb + 2'd1;
                end
            end else if (ps && !scl[g]) begin
                pl <= (bc == 4'd8) && !nack_cfg[g][nb];
            end
        end

        assign pull[g]    = pl;
        assign ev_stb[g]  = stb;
        assign ev_code[g] = code;
    end

    always @(posedge clk) begin
        if (ev_stb[0]) log_q.push_back(int'(ev_code[0]));
    end

    // Waveform compare against the model stream.
    always @(negedge clk) begin
        logic [4:0] e;
        logic [4:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {scl[sel], sda_oe[sel], busy[sel], done[sel], aerr[sel]};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL wave dut%0d t=%0t: scl/sda_oe/busy/done/ack_error got %b required %b",
                         sel, $time, a, e);
            end
        end
    end

    task automatic check(input string nm, input int got, input int req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", nm, got, req);
        end
    endtask

    // Model: expected per-cycle outputs of one transaction plus the 4-cycle
    // DONE/IDLE tail; fd = offset of first tx_done high from acceptance.
    task automatic push_txn(input int c, input logic [7:0] b1, input logic [7:0] b2,
                            input int nack_at, output int fd);
        logic [7:0] bytes [3];
        logic [2:0] qs [$];  // {scl, sda_oe, ack_error} per quarter
        logic       ae;
        logic       v;
        ae = 1'b0;
        bytes[0] = 8'h7E; bytes[1] = b1; bytes[2] = b2;
        qs.push_back({2'b10, ae});
        qs.push_back({2'b11, ae});
        for (int i = 0; i < 3; i++) begin
            for (int j = 7; j >= 0; j--) begin
                v = bytes[i][j];
                qs.push_back({1'b0, ~v, ae});
                qs.push_back({1'b1, ~v, ae});
                qs.push_back({1'b1, ~v, ae});
                qs.push_back({1'b0, ~v, ae});
            end
            qs.push_back({2'b00, ae});
            qs.push_back({2'b10, ae});
            qs.push_back({2'b10, ae});
            if (i == nack_at) ae = 1'b1;
            qs.push_back({2'b00, ae});
            if (i == nack_at) break;
        end
        qs.push_back({2'b01, ae});
        qs.push_back({2'b11, ae});
        qs.push_back({2'b10, ae});
        qs.push_back({2'b10, ae});
        foreach (qs[i]) begin
            for (int k = 0; k < c; k++) exp_q.push_back({qs[i][2], qs[i][1], 1'b1, 1'b0, qs[i][0]});
        end
        exp_q.push_back({4'b1000, ae});
        exp_q.push_back({4'b1001, ae});
        exp_q.push_back({4'b1001, ae});
        exp_q.push_back({4'b1000, ae});
        fd = qs.size() * c + 1;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (exp_q.size() > 0 && n < 60000) begin
            @(negedge clk); #1; n++;
        end
        check({nm, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic check_log(input string nm, input int start);
        check({nm, "_log_len"}, log_q.size() - start, exp_log.size());
        foreach (exp_log[i]) check({nm, "_log"}, log_q[start + i], exp_log[i]);
    endtask

    task automatic run_txn(input int s, input int c, input logic [7:0] b1, input logic [7:0] b2,
                           input int nack_at, input int lat_req, input int chg_k, input string nm);
        int fd;
        int k;
        @(negedge clk); #1;
        sel = s; reg_addr = b1; tx_data = b2; tx_en[s] = 1'b1;
        push_txn(c, b1, b2, nack_at, fd);
        check({nm, "_model_lat"}, fd, lat_req);
        @(posedge clk); #1;
        tx_en[s] = 1'b0;
        k = 0;
        @(negedge clk);
        while (done[s] !== 1'b1 && k < lat_req + 100) begin
            @(negedge clk);
            k++;
            if (k == chg_k) begin
                tx_data = 8'h55; reg_addr = 8'hAA;
            end
        end
        check({nm, "_dut_lat"}, k, lat_req);
        wait_drain(nm);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int ls;
        int fd;
        int idx;
        int guard;
        logic ph;
        logic [7:0] cmds [10];
        cmds = '{8'hE2, 8'hA2, 8'hA0, 8'hC8, 8'h25, 8'h81, 8'h20, 8'h2F, 8'hAF, 8'h40};

        // Reset state
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check("rst_scl", int'(scl[g]), 1);
            check("rst_sda_oe", int'(sda_oe[g]), 0);
            check("rst_busy", int'(busy[g]), 0);
            check("rst_done", int'(done[g]), 0);
            check("rst_aerr", int'(aerr[g]), 0);
        end
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Full ACKed write
        ls = log_q.size();
        run_txn(0, 4, 8'h00, 8'hE2, -1, 457, -1, "t1");
        exp_log = '{256, 8'h7E, 8'h00, 8'hE2, 257};
        check_log("t1", ls);
        check("t1_aerr", int'(aerr[0]), 0);

        // NACK on address byte
        nack_cfg[0] = 3'b001;
        ls = log_q.size();
        run_txn(0, 4, 8'h00, 8'hE2, 0, 169, -1, "t2");
        exp_log = '{256, 8'h7E, 257};
        check_log("t2", ls);
        check("t2_aerr", int'(aerr[0]), 1);

        // Next acceptance clears ack_error; inputs changed mid byte 1
        nack_cfg[0] = 3'b000;
        ls = log_q.size();
        run_txn(0, 4, 8'h00, 8'hE2, -1, 457, 200, "t3");
        exp_log = '{256, 8'h7E, 8'h00, 8'hE2, 257};
        check_log("t3", ls);
        check("t3_aerr", int'(aerr[0]), 0);

        // NACK on data byte
        nack_cfg[0] = 3'b100;
        ls = log_q.size();
        run_txn(0, 4, 8'h5A, 8'hC3, 2, 457, -1, "t4");
        exp_log = '{256, 8'h7E, 8'h5A, 8'hC3, 257};
        check_log("t4", ls);
        check("t4_aerr", int'(aerr[0]), 1);
        nack_cfg[0] = 3'b000;

        // Init sequencer: tx_en held, tx_done sampled on alternate clocks
        @(negedge clk); #1;
        sel = 0; reg_addr = 8'h00; tx_data = cmds[0]; tx_en[0] = 1'b1;
        ls = log_q.size();
        exp_log.delete();
        for (int i = 0; i < 10; i++) begin
            push_txn(4, 8'h00, cmds[i], -1, fd);
            exp_log.push_back(256); exp_log.push_back(8'h7E); exp_log.push_back(8'h00);
            exp_log.push_back(int'(cmds[i])); exp_log.push_back(257);
        end
        check("t5_model_lat", fd, 457);
        idx = 0; ph = 1'b0; guard = 0;
        while (idx < 10 && guard < 6000) begin
            @(negedge clk);
            guard++;
            ph = ~ph;
            if (ph && done[0]) begin
                idx++;
                if (idx < 10) tx_data = cmds[idx];
                else tx_en[0] = 1'b0;
            end
        end
        check("t5_init_complete", idx, 10);
        tx_en[0] = 1'b0;
        wait_drain("t5");
        repeat (20) @(negedge clk);
        check("t5_idle_busy", int'(busy[0]), 0);
        check_log("t5", ls);

        // Reset mid-bit of byte 2, then a clean transaction
        @(negedge clk); #1;
        sel = 0; reg_addr = 8'h00; tx_data = 8'hE2; tx_en[0] = 1'b1;
        push_txn(4, 8'h00, 8'hE2, -1, fd);
        @(posedge clk); #1;
        tx_en[0] = 1'b0;
        repeat (333) @(negedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_scl", int'(scl[0]), 1);
        check("t6_rst_sda_oe", int'(sda_oe[0]), 0);
        check("t6_rst_busy", int'(busy[0]), 0);
        check("t6_rst_done", int'(done[0]), 0);
        repeat (3) @(negedge clk);
        check("t6_rst_done_hold", int'(done[0]), 0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        ls = log_q.size();
        run_txn(0, 4, 8'h00, 8'hE2, -1, 457, -1, "t6");
        exp_log = '{256, 8'h7E, 8'h00, 8'hE2, 257};
        check_log("t6", ls);

        // CLK_DIV = 2, full write
        run_txn(1, 2, 8'h3C, 8'hA5, -1, 229, -1, "t7");
        check("t7_aerr", int'(aerr[1]), 0);

        // CLK_DIV = 1023, address NACK
        nack_cfg[2] = 3'b001;
        run_txn(2, 1023, 8'h00, 8'hE2, 0, 42967, -1, "t8");
        check("t8_aerr", int'(aerr[2]), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
- Downstream consumer of the static LCD init sequencer.
- Takes one (reg_addr, tx_data) pair per handshake and emits a single I2C write transaction: START, device address + W, reg_addr byte, tx_data byte, STOP.
- Drives an open-drain SCL/SDA pair to the LCD controller and reports completion through tx_done.

Parameters:
- CLK_DIV, 4: system clocks per quarter SCL period (SCL period = 4*CLK_DIV clocks); legal 2..1023.
- DEV_ADDR, 7'h3F: 7-bit I2C device address; sent as {DEV_ADDR,1'b0}.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset (0 = reset)
- reg_addr  input  8  second byte on bus (control/register byte)
- tx_data  input  8  third byte on bus
- tx_en  input  1  request; level-sampled
- tx_done  output  1  completion strobe, 2 clk cycles wide
- busy  output  1  high from acceptance through end of STOP
- ack_error  output  1  high if slave NACKed any byte of the last transaction
- scl_o  output  1  SCL drive; 1 = released, 0 = pull low
- sda_oe  output  1  1 = pull SDA low, 0 = release
- sda_i  input  1  sampled SDA line (synchronised internally, 2 flops)

Behaviour:
- Reset (rst=0, async): state IDLE; scl_o=1, sda_oe=0, tx_done=0, busy=0, ack_error=0; quarter counter, bit counter, shift register cleared. Mid-transaction reset releases the bus immediately. No STOP is generated.
- Quarter tick: counter 0..CLK_DIV-1; tick when it reaches CLK_DIV-1. Counter held at 0 in IDLE.
- Acceptance: in IDLE with tx_en=1 and tx_done=0, on the clk edge:
  - latch {DEV_ADDR,0}, reg_addr, tx_data into a 24-bit shift register;
  - busy<=1, ack_error<=0, go to START.
  - Inputs are ignored after acceptance; changes mid-transaction have no effect.
- States, each step lasting one quarter:
  - START: q0 SCL=1/SDA released; q1 SCL=1/SDA low. Then BIT.
  - BIT: per bit, MSB first.
    - q0 SCL low, SDA set (sda_oe = ~bit).
    - q1, q2 SCL high.
    - q3 SCL low.
    - After 8 bits, go to ACK.
  - ACK: SDA released. Same 4-quarter SCL pattern. sda_i sampled at end of q2; 1 = NACK.
    - ACK after byte 0 or 1: next byte.
    - ACK after byte 2: STOP.
    - NACK: ack_error<=1, go straight to STOP; remaining bytes skipped.
  - STOP: q0 SCL low/SDA low; q1 SCL high/SDA low; q2 SCL high/SDA released; q3 bus idle (both released). Then DONE.
  - DONE: tx_done=1 for exactly 2 clk cycles, busy=0; then IDLE.
    - 2 cycles so a consumer sampling on alternate clocks sees it exactly once.
    - tx_en is not accepted while tx_done=1.
- Latency, full ACKed transaction: 2 + 27*4 + 4 = 114 quarters.
  - tx_done first high exactly 114*CLK_DIV + 1 clocks after the accepting edge.
- Back-to-back: requester may hold tx_en high permanently. A new transaction is accepted on the first IDLE cycle after tx_done falls, with the inputs present on that edge.
- ack_error holds until the next acceptance.
- SDA changes only while SCL low, except START/STOP edges. SCL never stretched; clock stretching unsupported.

Test Plan:
- CLK_DIV=4, DEV_ADDR=7'h3F, reg_addr=8'h00, tx_data=8'hE2, slave model ACKs all:
  - bus decodes START, 0x7E, ACK, 0x00, ACK, 0xE2, ACK, STOP;
  - tx_done high 2 cycles starting at clock 457 after acceptance;
  - ack_error=0.
- Slave NACKs address byte:
  - only 0x7E clocked, then STOP;
  - ack_error=1, tx_done pulses 2 cycles;
  - next tx_en clears ack_error on acceptance.
- Drive with the init sequencer (tx_en held high, samples tx_done on alternate clocks), 10 commands E2,A2,A0,C8,25,81,20,2F,AF,40:
  - exactly 10 transactions in that order;
  - no duplicate or skipped byte;
  - sequencer init_complete rises.
- tx_data changed from 8'hE2 to 8'h55 during byte 1:
  - bus still carries 0xE2.
- rst=0 asserted mid-bit of byte 2:
  - same cycle: scl_o=1, sda_oe=0, busy=0, no tx_done;
  - after release: IDLE, next tx_en starts a clean START.
- CLK_DIV=2 and CLK_DIV=1023:
  - SCL high/low each 2*CLK_DIV clocks;
  - latency formula holds.
